// File: rtl/pcm_frame_fifo.sv
// Frame-aware PCM sample FIFO: accepts channel-ordered samples,
// releases only complete frames, drops partial frames on order errors.
module pcm_frame_fifo #(
  parameter  int DATA_W = 24,
  parameter  int N_CH   = 2,
  parameter  int DEPTH  = 8,
  localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int LVL_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CH_W-1:0]   in_ch,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CH_W-1:0]   out_ch,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sof,
  output logic [LVL_W-1:0]  level,
  output logic              seq_err,
  output logic [15:0]       err_cnt
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {HUNT, LOCK} state_t;

  state_t             state_q, state_n;
  logic [CH_W-1:0]    exp_q, exp_n;
  logic [PTR_W-1:0]   wr_q, wr_n;
  logic [PTR_W-1:0]   cmt_q, cmt_n;
  logic [PTR_W-1:0]   rd_q, rd_n;
  logic [LVL_W-1:0]   used_q, used_n;
  logic [LVL_W-1:0]   lvl_q, lvl_n;
  logic               err_n;
  logic [15:0]        cnt_n;
  logic               we;
  logic [PTR_W-1:0]   waddr;
  logic               push, pop;

  logic [CH_W-1:0]    mem_ch   [DEPTH];
  logic [DATA_W-1:0]  mem_data [DEPTH];

  function automatic logic [PTR_W-1:0] inc(
    input logic [PTR_W-1:0] p
  );
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign in_ready  = (used_q < LVL_W'(DEPTH));
  assign out_valid = (lvl_q != '0);
  assign out_ch    = mem_ch[rd_q];
  assign out_data  = mem_data[rd_q];
  assign out_sof   = (out_ch == '0);
  assign level     = lvl_q;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Pop first, then apply the input event on the post-pop counts
  always_comb begin
    state_n = state_q;
    exp_n   = exp_q;
    wr_n    = wr_q;
    cmt_n   = cmt_q;
    rd_n    = rd_q;
    used_n  = used_q;
    lvl_n   = lvl_q;
    err_n   = 1'b0;
    cnt_n   = err_cnt;
    we      = 1'b0;
    waddr   = wr_q;
    if (pop) begin
      rd_n   = inc(rd_q);
      lvl_n  = lvl_q - LVL_W'(1);
      used_n = used_q - LVL_W'(1);
    end
    if (push) begin
      unique case (state_q)
        HUNT: begin
          if (in_ch == '0) begin
            we      = 1'b1;
            wr_n    = inc(wr_q);
            used_n  = used_n + LVL_W'(1);
            state_n = LOCK;
            if (N_CH == 1) begin
              cmt_n = inc(wr_q);
              lvl_n = lvl_n + LVL_W'(1);
              exp_n = '0;
            end else begin
              exp_n = CH_W'(1);
            end
          end
        end
        LOCK: begin
          if (in_ch == exp_q) begin
            we     = 1'b1;
            wr_n   = inc(wr_q);
            used_n = used_n + LVL_W'(1);
            if (exp_q == CH_W'(N_CH - 1)) begin
              cmt_n = inc(wr_q);
              lvl_n = lvl_n + LVL_W'(N_CH);
              exp_n = '0;
            end else begin
              exp_n = exp_q + CH_W'(1);
            end
          end else begin
            err_n = 1'b1;
            if (err_cnt != 16'hFFFF)
              cnt_n = err_cnt + 16'd1;
            if (in_ch == '0) begin
              we     = 1'b1;
              waddr  = cmt_q;
              wr_n   = inc(cmt_q);
              used_n = lvl_n + LVL_W'(1);
              exp_n  = CH_W'(1);
            end else begin
              wr_n    = cmt_q;
              used_n  = lvl_n;
              exp_n   = '0;
              state_n = HUNT;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Control state; flush clears like reset
  always_ff @(posedge clk) begin
    if (!rstn || flush) begin
      state_q <= HUNT;
      exp_q   <= '0;
      wr_q    <= '0;
      cmt_q   <= '0;
      rd_q    <= '0;
      used_q  <= '0;
      lvl_q   <= '0;
      seq_err <= 1'b0;
    end else begin
      state_q <= state_n;
      exp_q   <= exp_n;
      wr_q    <= wr_n;
      cmt_q   <= cmt_n;
      rd_q    <= rd_n;
      used_q  <= used_n;
      lvl_q   <= lvl_n;
      seq_err <= err_n;
    end
  end

  // Error counter survives flush, only reset clears it
  always_ff @(posedge clk) begin
    if (!rstn)
      err_cnt <= '0;
    else if (!flush)
      err_cnt <= cnt_n;
  end

  // Sample storage
  always_ff @(posedge clk) begin
    if (we && rstn && !flush) begin
      mem_ch[waddr]   <= in_ch;
      mem_data[waddr] <= in_data;
    end
  end

endmodule
